sum_uart_tx: RTL and testbench

SUM_UART_TX -- requirements
Module: sum_uart_tx

---
 rtl/sum_uart_tx.sv | 150 +++++++++++++++
 tb/tb_sum_uart_tx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: adds two bytes and sends the 8-bit sum as one UART frame
// (start bit, sum[0]..sum[7], optional even parity, stop bit).
// Optional feature macro: SUM_UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1 instead of 8N1).
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

`ifdef SUM_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    sum_q, sum_d;
    logic          bit_end;

    // The current bit period ends when the down-counter has reached zero.
    assign bit_end = (cnt_q == '0);

    // Next-state logic; tx_d is the line value for the cycle after this edge,
    // so the serial output always comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = 3'd0;
                if (start) begin
                    state_d = START;
                    sum_d   = a + b;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = RELOAD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = sum_q[0];
                    cnt_d   = RELOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef SUM_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^sum_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = sum_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef SUM_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    cnt_d   = RELOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset forces the line high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Testbench for sum_uart_tx: one instance at 4 clocks per bit and one at 2,
// each frame compared cycle by cycle against a bit-list model of the frame.
module tb_sum_uart_tx;

`ifdef SUM_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] a4, b4, a2, b2;
    logic       start4, start2;
    logic       tx4, busy4, done4, tx2, busy2, done2;
    logic [7:0] sum4, sum2;

    int vectors     = 0;
    int miscompares = 0;

    sum_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .start(start4),
        .tx(tx4), .busy(busy4), .done(done4), .sum(sum4)
    );

    sum_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .a(a2), .b(b2), .start(start2),
        .tx(tx2), .busy(busy2), .done(done2), .sum(sum2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit sel, input logic [7:0] av, input logic [7:0] bv, input logic st);
        if (sel) begin a2 = av; b2 = bv; start2 = st; end
        else     begin a4 = av; b4 = bv; start4 = st; end
    endtask

    task automatic set_start(input bit sel, input logic st);
        if (sel) start2 = st; else start4 = st;
    endtask

    task automatic check_outputs(input bit sel, input string tag, input logic etx,
                                 input logic ebusy, input logic edone, input logic [7:0] esum);
        chk({tag, ".tx"},   sel ? tx2 : tx4, etx);
        chk({tag, ".busy"}, sel ? busy2 : busy4, ebusy);
        chk({tag, ".done"}, sel ? done2 : done4, edone);
        chk({tag, ".sum"},  sel ? sum2 : sum4, esum);
    endtask

    // Line level during bit slot idx of a frame carrying s.
    function automatic logic exp_bit(input logic [7:0] s, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 1 && idx <= 8) return s[idx-1];
        if (NBITS == 11 && idx == 9) return logic'($countones(s) % 2);
        return 1'b1;
    endfunction

    // Send one frame and check every cycle from acceptance to done.
    // hold: leave start high after done; repulse: pulse start with new
    // operands mid-frame; stop_at: return early after that cycle (-1 = never).
    task automatic frame(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                         input bit hold, input bit repulse, input int stop_at);
        int cpb;
        int total;
        logic [7:0] s;
        cpb   = sel ? 2 : 4;
        total = NBITS * cpb;
        s     = 8'((int'(av) + int'(bv)) % 256);
        @(negedge clk);
        drive(sel, av, bv, 1'b1);
        $display("frame cpb=%0d a=%02h b=%02h sum=%02h hold=%0d repulse=%0d", cpb, av, bv, s, hold, repulse);
        for (int k = 0; k <= total; k++) begin
            @(posedge clk);
            #1;
            if (k < total)
                check_outputs(sel, $sformatf("cpb%0d.k%0d", cpb, k), exp_bit(s, k / cpb), 1'b1, 1'b0, s);
            else
                check_outputs(sel, $sformatf("cpb%0d.done", cpb), 1'b1, 1'b0, 1'b1, s);
            if (k == stop_at) return;
            if (!hold) set_start(sel, 1'b0);
            if (repulse && (k == 4 || k == 19))
                drive(sel, 8'($urandom), 8'($urandom), 1'b1);
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            check_outputs(sel, $sformatf("cpb%0d.idle", cpb), 1'b1, 1'b0, 1'b0, s);
        end
    endtask

    initial begin
        rst = 1'b1;
        a4 = 8'h00; b4 = 8'h00; start4 = 1'b0;
        a2 = 8'h00; b2 = 8'h00; start2 = 1'b0;
        #1;
        check_outputs(1'b0, "reset4", 1'b1, 1'b0, 1'b0, 8'h00);
        check_outputs(1'b1, "reset2", 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed frames, first one accepted on the first edge after reset.
        frame(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, -1);
        frame(1'b0, 8'hFF, 8'h02, 1'b0, 1'b0, -1);
        frame(1'b1, 8'hFF, 8'h02, 1'b0, 1'b0, -1);

        // Mid-frame start pulses with new operands are ignored.
        frame(1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, -1);

        // Start held high: frames back to back, busy low only in done cycles.
        frame(1'b0, 8'h81, 8'h7E, 1'b1, 1'b0, -1);
        frame(1'b0, 8'h55, 8'h11, 1'b1, 1'b0, -1);
        frame(1'b0, 8'h0F, 8'hF0, 1'b0, 1'b0, -1);
        frame(1'b1, 8'h01, 8'h01, 1'b1, 1'b0, -1);
        frame(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, -1);

        // Asynchronous reset in the middle of a frame.
        frame(1'b0, 8'h6B, 8'h29, 1'b0, 1'b0, 13);
        #1;
        rst = 1'b1;
        #1;
        check_outputs(1'b0, "rst_async", 1'b1, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check_outputs(1'b0, "rst_held", 1'b1, 1'b0, 1'b0, 8'h00);
        start4 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(1'b0, "rst_after", 1'b1, 1'b0, 1'b0, 8'h00);
        frame(1'b0, 8'h6B, 8'h29, 1'b0, 1'b0, -1);

        // Random operands on both instances.
        for (int i = 0; i < 8; i++)
            frame(bit'(i % 2), 8'($urandom), 8'($urandom), 1'b0, bit'($urandom_range(0, 1)), -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
